// File: rtl/divisor_pkg.sv
// -----------------------------------------------------------------------------
// divisor_pkg
// Shared types and helpers for the sequential divider slice.
//   estado_t             : controller states (NORM only used with early exit)
//   DIVISOR_SIZE_DEF     : default operand width
//   f_cnt_w()            : iteration-counter width, $clog2(size+1)
//   f_cociente_div_cero(): quotient pattern returned on divide-by-zero
// -----------------------------------------------------------------------------
package divisor_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        NORM = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } estado_t;

    localparam int DIVISOR_SIZE_DEF = 32;

    // Widest operand the divide-by-zero pattern covers.
    localparam int DIVISOR_MAX_SIZE = 256;

    // Counter must hold the value SIZE itself, hence SIZE+1 codes.
    function automatic int f_cnt_w(input int size);
        return $clog2(size + 1);
    endfunction

    // All-ones quotient; callers keep the low SIZE bits.
    function automatic logic [DIVISOR_MAX_SIZE-1:0] f_cociente_div_cero();
        return {DIVISOR_MAX_SIZE{1'b1}};
    endfunction

endpackage

// File: rtl/divisor_lzc.sv
// -----------------------------------------------------------------------------
// divisor_lzc
// Combinational leading-zero counter used by the early-exit build of the
// divider (DIVISOR_EARLY_EXIT_EN).
// Ports:
//   i_dato [SIZE-1:0]  : value to scan, MSB first
//   o_lz   [CNT_W-1:0] : number of leading zeros (SIZE when i_dato == 0)
// -----------------------------------------------------------------------------
module divisor_lzc
    import divisor_pkg::*;
#(
    parameter  int SIZE  = DIVISOR_SIZE_DEF,
    localparam int CNT_W = f_cnt_w(SIZE)
) (
    input  logic [SIZE-1:0]  i_dato,
    output logic [CNT_W-1:0] o_lz
);

    logic w_hallado;

    // Priority scan from the MSB: the first set bit fixes the count.
    always_comb begin
        o_lz      = CNT_W'(SIZE);
        w_hallado = 1'b0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (!w_hallado && i_dato[i]) begin
                o_lz      = CNT_W'(SIZE - 1 - i);
                w_hallado = 1'b1;
            end else begin
                o_lz      = o_lz;
                w_hallado = w_hallado;
            end
        end
    end

endmodule

// File: rtl/divisor_secuencial_param.sv
// -----------------------------------------------------------------------------
// divisor_secuencial_param
// Multi-cycle restoring divider, one quotient bit per clock, with per-operation
// signed/unsigned mode, busy flag and divide-by-zero flag.
// Optional build macro: DIVISOR_EARLY_EXIT_EN adds a NORM state that skips the
// leading zeros of |numerador| (same results, shorter latency).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : request, accepted only in IDLE
//   signo               : 1 = signed two's complement, 0 = unsigned
//   numerador           : dividend  (captured with start)
//   denominador         : divisor   (captured with start)
//   cociente, resto     : quotient / remainder, held until next accepted start
//   done                : one-cycle pulse when results are valid
//   busy                : high while an operation is in flight
//   div_cero            : divide-by-zero flag, held with results
// -----------------------------------------------------------------------------
module divisor_secuencial_param
    import divisor_pkg::*;
#(
    parameter int SIZE = DIVISOR_SIZE_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            signo,
    input  logic [SIZE-1:0] numerador,
    input  logic [SIZE-1:0] denominador,
    output logic [SIZE-1:0] cociente,
    output logic [SIZE-1:0] resto,
    output logic            done,
    output logic            busy,
    output logic            div_cero
);

    localparam int                        CNT_W          = f_cnt_w(SIZE);
    localparam logic [DIVISOR_MAX_SIZE-1:0] C_PATRON     = f_cociente_div_cero();
    localparam logic [SIZE-1:0]           C_COC_DIV_CERO = C_PATRON[SIZE-1:0];
    localparam logic [SIZE-1:0]           C_UNO          = SIZE'(1);
    localparam logic [SIZE-1:0]           C_CERO         = {SIZE{1'b0}};
    localparam logic [CNT_W-1:0]          C_ITER         = CNT_W'(SIZE);
    localparam logic [CNT_W-1:0]          C_CNT_UNO      = CNT_W'(1);

    // Two's-complement negation in SIZE bits (MIN maps to itself, which
    // read as unsigned is exactly 2^(SIZE-1)).
    function automatic logic [SIZE-1:0] f_neg(input logic [SIZE-1:0] v);
        return ~v + C_UNO;
    endfunction

    estado_t r_estado;
    estado_t w_estado_sig;

    logic [SIZE-1:0]  r_dvd;     // dividend shifting out, quotient shifting in
    logic [SIZE-1:0]  r_dsr;     // divisor magnitude
    logic [SIZE:0]    r_rem;     // partial remainder
    logic [CNT_W-1:0] r_cnt;     // iterations left
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_dz;
    logic [SIZE-1:0]  r_cociente;
    logic [SIZE-1:0]  r_resto;
    logic             r_done;
    logic             r_busy;
    logic             r_div_cero;

    logic             w_num_neg;
    logic             w_den_neg;
    logic [SIZE-1:0]  w_num_mag;
    logic [SIZE-1:0]  w_den_mag;
    logic             w_den_cero;
    logic [SIZE+1:0]  w_shift;
    logic [SIZE+1:0]  w_sub;
    logic             w_neg;

    // Operand sign/magnitude decode on the capture cycle.
    always_comb begin
        w_num_neg  = signo & numerador[SIZE-1];
        w_den_neg  = signo & denominador[SIZE-1];
        w_num_mag  = w_num_neg ? f_neg(numerador) : numerador;
        w_den_mag  = w_den_neg ? f_neg(denominador) : denominador;
        w_den_cero = (denominador == C_CERO);
    end

    // One restoring step: trial subtract in SIZE+2 bits so the borrow
    // shows up in the top bit.
    always_comb begin
        w_shift = {r_rem, r_dvd[SIZE-1]};
        w_sub   = w_shift - {2'b00, r_dsr};
        w_neg   = w_sub[SIZE+1];
    end

`ifdef DIVISOR_EARLY_EXIT_EN
    logic [CNT_W-1:0] w_lz;

    divisor_lzc #(
        .SIZE (SIZE)
    ) u_lzc (
        .i_dato (r_dvd),
        .o_lz   (w_lz)
    );
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= IDLE;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // Next-state logic.
    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            IDLE: begin
                if (start) begin
                    if (w_den_cero) begin
                        w_estado_sig = FIX;
                    end else begin
`ifdef DIVISOR_EARLY_EXIT_EN
                        w_estado_sig = NORM;
`else
                        w_estado_sig = CALC;
`endif
                    end
                end else begin
                    w_estado_sig = IDLE;
                end
            end
`ifdef DIVISOR_EARLY_EXIT_EN
            NORM: begin
                if (r_dvd == C_CERO) begin
                    w_estado_sig = FIX;
                end else begin
                    w_estado_sig = CALC;
                end
            end
`endif
            CALC: begin
                if (r_cnt == C_CNT_UNO) begin
                    w_estado_sig = FIX;
                end else begin
                    w_estado_sig = CALC;
                end
            end
            FIX:     w_estado_sig = DONE;
            DONE:    w_estado_sig = IDLE;
            default: w_estado_sig = IDLE;
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd      <= {SIZE{1'b0}};
            r_dsr      <= {SIZE{1'b0}};
            r_rem      <= {(SIZE+1){1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_dz       <= 1'b0;
            r_cociente <= {SIZE{1'b0}};
            r_resto    <= {SIZE{1'b0}};
            r_div_cero <= 1'b0;
        end else begin
            case (r_estado)
                IDLE: begin
                    if (start) begin
                        r_dvd      <= w_num_mag;
                        r_dsr      <= w_den_mag;
                        r_cnt      <= C_ITER;
                        r_q_neg    <= w_num_neg ^ w_den_neg;
                        r_r_neg    <= w_num_neg;
                        r_dz       <= w_den_cero;
                        r_div_cero <= 1'b0;
                        // On divide-by-zero the remainder path re-applies the
                        // dividend sign, giving back numerador unchanged.
                        if (w_den_cero) begin
                            r_rem <= {1'b0, w_num_mag};
                        end else begin
                            r_rem <= {(SIZE+1){1'b0}};
                        end
                    end
                end
`ifdef DIVISOR_EARLY_EXIT_EN
                NORM: begin
                    // Leading zeros would only produce leading quotient zeros.
                    r_dvd <= r_dvd << w_lz;
                    r_cnt <= C_ITER - w_lz;
                end
`endif
                CALC: begin
                    r_rem <= w_neg ? w_shift[SIZE:0] : w_sub[SIZE:0];
                    r_dvd <= {r_dvd[SIZE-2:0], ~w_neg};
                    r_cnt <= r_cnt - C_CNT_UNO;
                end
                FIX: begin
                    if (r_dz) begin
                        r_cociente <= C_COC_DIV_CERO;
                    end else if (r_q_neg) begin
                        r_cociente <= f_neg(r_dvd);
                    end else begin
                        r_cociente <= r_dvd;
                    end
                    r_resto    <= r_r_neg ? f_neg(r_rem[SIZE-1:0]) : r_rem[SIZE-1:0];
                    r_div_cero <= r_dz;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Registered handshake flags, one cycle behind the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_done <= (r_estado == DONE);
            r_busy <= (r_estado == NORM) || (r_estado == CALC) || (r_estado == FIX);
        end
    end

    assign cociente = r_cociente;
    assign resto    = r_resto;
    assign done     = r_done;
    assign busy     = r_busy;
    assign div_cero = r_div_cero;

endmodule

// File: tb/tb_divisor_secuencial_param.sv
module tb_divisor_secuencial_param;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signo;
    logic [31:0] numerador;
    logic [31:0] denominador;
    logic [31:0] cociente;
    logic [31:0] resto;
    logic        done;
    logic        busy;
    logic        div_cero;

    int n_eval = 0;
    int n_fail = 0;

`ifdef DIVISOR_EARLY_EXIT_EN
    localparam int LAT_100_7 = 10;   // lz(100)=25 -> 3+7
    localparam int LAT_FULL  = 35;   // lz=0
    localparam int LAT_SMALL = 6;    // lz(7)=29 or lz(9)=28 handled per test
`else
    localparam int LAT_100_7 = 34;
    localparam int LAT_FULL  = 34;
    localparam int LAT_SMALL = 34;
`endif
    localparam int LAT_DZ = 2;

    divisor_secuencial_param #(.SIZE(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signo       (signo),
        .numerador   (numerador),
        .denominador (denominador),
        .cociente    (cociente),
        .resto       (resto),
        .done        (done),
        .busy        (busy),
        .div_cero    (div_cero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one operation; report latency (-1 on timeout), busy errors,
    // whether done lasted more than one cycle, and div_cero after accept.
    task automatic do_op(input logic s, input logic [31:0] n, input logic [31:0] d,
                         output int lat, output int busy_bad, output int done_bad,
                         output logic dz_acc);
        @(negedge clk);
        signo = s; numerador = n; denominador = d; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dz_acc = div_cero;
        numerador = $urandom(); denominador = $urandom();
        lat = -1; busy_bad = 0; done_bad = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                if (busy) busy_bad++;
                break;
            end
            if (!busy) busy_bad++;
        end
        if (lat > 0) begin
            @(posedge clk);
            #1;
            if (done) done_bad = 1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; signo = 1'b0;
        numerador = 32'd0; denominador = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        n_eval++; if (cociente !== 32'h0) begin n_fail++; $display("FAIL reset_cociente got %h want %h", cociente, 32'h0); end
        n_eval++; if (resto !== 32'h0) begin n_fail++; $display("FAIL reset_resto got %h want %h", resto, 32'h0); end
        n_eval++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_eval++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_eval++; if (div_cero !== 1'b0) begin n_fail++; $display("FAIL reset_div_cero got %b want 0", div_cero); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        int lat, bb, db; logic dza;
        do_op(1'b0, 32'd100, 32'd7, lat, bb, db, dza);
        n_eval++; if (cociente !== 32'd14) begin n_fail++; $display("FAIL u100_7_coc got %h want %h", cociente, 32'd14); end
        n_eval++; if (resto !== 32'd2) begin n_fail++; $display("FAIL u100_7_rem got %h want %h", resto, 32'd2); end
        n_eval++; if (div_cero !== 1'b0) begin n_fail++; $display("FAIL u100_7_dz got %b want 0", div_cero); end
        n_eval++; if (lat !== LAT_100_7) begin n_fail++; $display("FAIL u100_7_latency got %0d want %0d", lat, LAT_100_7); end
        n_eval++; if (bb !== 0) begin n_fail++; $display("FAIL u100_7_busy got %0d bad cycles want 0", bb); end
        n_eval++; if (db !== 0) begin n_fail++; $display("FAIL u100_7_done_width got %0d want 0", db); end
        do_op(1'b0, 32'hFFFF_FFF9, 32'd2, lat, bb, db, dza);
        n_eval++; if (cociente !== 32'h7FFF_FFFC) begin n_fail++; $display("FAIL ubig_coc got %h want %h", cociente, 32'h7FFF_FFFC); end
        n_eval++; if (resto !== 32'd1) begin n_fail++; $display("FAIL ubig_rem got %h want %h", resto, 32'd1); end
        n_eval++; if (lat !== LAT_FULL) begin n_fail++; $display("FAIL ubig_latency got %0d want %0d", lat, LAT_FULL); end
    endtask

    task automatic test_signed();
        int lat, bb, db; logic dza;
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, bb, db, dza);
        n_eval++; if (cociente !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL sm7_2_coc got %h want %h", cociente, 32'hFFFF_FFFD); end
        n_eval++; if (resto !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sm7_2_rem got %h want %h", resto, 32'hFFFF_FFFF); end
        n_eval++; if (lat !== LAT_SMALL) begin n_fail++; $display("FAIL sm7_2_latency got %0d want %0d", lat, LAT_SMALL); end
        do_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat, bb, db, dza);
        n_eval++; if (cociente !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL s7_m2_coc got %h want %h", cociente, 32'hFFFF_FFFD); end
        n_eval++; if (resto !== 32'd1) begin n_fail++; $display("FAIL s7_m2_rem got %h want %h", resto, 32'd1); end
    endtask

    task automatic test_div_cero();
        int lat, bb, db; logic dza;
        for (int m = 0; m < 2; m++) begin
            do_op(m[0], 32'd55, 32'd0, lat, bb, db, dza);
            n_eval++; if (cociente !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz%0d_coc got %h want %h", m, cociente, 32'hFFFF_FFFF); end
            n_eval++; if (resto !== 32'd55) begin n_fail++; $display("FAIL dz%0d_rem got %h want %h", m, resto, 32'd55); end
            n_eval++; if (div_cero !== 1'b1) begin n_fail++; $display("FAIL dz%0d_flag got %b want 1", m, div_cero); end
            n_eval++; if (lat !== LAT_DZ) begin n_fail++; $display("FAIL dz%0d_latency got %0d want %0d", m, lat, LAT_DZ); end
        end
        repeat (3) @(posedge clk);
        #1;
        n_eval++; if (cociente !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_hold_coc got %h want %h", cociente, 32'hFFFF_FFFF); end
        n_eval++; if (div_cero !== 1'b1) begin n_fail++; $display("FAIL dz_hold_flag got %b want 1", div_cero); end
        do_op(1'b0, 32'd9, 32'd3, lat, bb, db, dza);
        n_eval++; if (dza !== 1'b0) begin n_fail++; $display("FAIL dz_clear_on_start got %b want 0", dza); end
        n_eval++; if (cociente !== 32'd3) begin n_fail++; $display("FAIL after_dz_coc got %h want %h", cociente, 32'd3); end
        n_eval++; if (resto !== 32'd0) begin n_fail++; $display("FAIL after_dz_rem got %h want %h", resto, 32'd0); end
        n_eval++; if (div_cero !== 1'b0) begin n_fail++; $display("FAIL after_dz_flag got %b want 0", div_cero); end
    endtask

    task automatic test_min_overflow();
        int lat, bb, db; logic dza;
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bb, db, dza);
        n_eval++; if (cociente !== 32'h8000_0000) begin n_fail++; $display("FAIL smin_coc got %h want %h", cociente, 32'h8000_0000); end
        n_eval++; if (resto !== 32'd0) begin n_fail++; $display("FAIL smin_rem got %h want %h", resto, 32'd0); end
        do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, bb, db, dza);
        n_eval++; if (cociente !== 32'd0) begin n_fail++; $display("FAIL umin_coc got %h want %h", cociente, 32'd0); end
        n_eval++; if (resto !== 32'h8000_0000) begin n_fail++; $display("FAIL umin_rem got %h want %h", resto, 32'h8000_0000); end
    endtask

    task automatic test_start_ignored();
        int n_done;
        @(negedge clk);
        signo = 1'b0; numerador = 32'd100; denominador = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        numerador = 32'd1; denominador = 32'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        n_eval++; if (n_done !== 1) begin n_fail++; $display("FAIL ignored_start_dones got %0d want 1", n_done); end
        n_eval++; if (cociente !== 32'd14) begin n_fail++; $display("FAIL ignored_start_coc got %h want %h", cociente, 32'd14); end
        n_eval++; if (resto !== 32'd2) begin n_fail++; $display("FAIL ignored_start_rem got %h want %h", resto, 32'd2); end
    endtask

    task automatic test_reset_abort();
        int n_done, lat, bb, db; logic dza;
        @(negedge clk);
        signo = 1'b0; numerador = 32'hFFFF_FFFF; denominador = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_eval++; if (cociente !== 32'h0) begin n_fail++; $display("FAIL abort_coc got %h want %h", cociente, 32'h0); end
        n_eval++; if (resto !== 32'h0) begin n_fail++; $display("FAIL abort_rem got %h want %h", resto, 32'h0); end
        n_eval++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        n_eval++; if (n_done !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d want 0", n_done); end
        do_op(1'b0, 32'd9, 32'd3, lat, bb, db, dza);
        n_eval++; if (cociente !== 32'd3) begin n_fail++; $display("FAIL post_abort_coc got %h want %h", cociente, 32'd3); end
        n_eval++; if (resto !== 32'd0) begin n_fail++; $display("FAIL post_abort_rem got %h want %h", resto, 32'd0); end
    endtask

`ifdef DIVISOR_EARLY_EXIT_EN
    task automatic test_early_exit();
        int lat, bb, db; logic dza;
        do_op(1'b0, 32'd5, 32'd1, lat, bb, db, dza);
        n_eval++; if (cociente !== 32'd5) begin n_fail++; $display("FAIL ee5_coc got %h want %h", cociente, 32'd5); end
        n_eval++; if (resto !== 32'd0) begin n_fail++; $display("FAIL ee5_rem got %h want %h", resto, 32'd0); end
        n_eval++; if (lat !== 6) begin n_fail++; $display("FAIL ee5_latency got %0d want 6", lat); end
        do_op(1'b0, 32'd0, 32'd3, lat, bb, db, dza);
        n_eval++; if (cociente !== 32'd0) begin n_fail++; $display("FAIL ee0_coc got %h want %h", cociente, 32'd0); end
        n_eval++; if (resto !== 32'd0) begin n_fail++; $display("FAIL ee0_rem got %h want %h", resto, 32'd0); end
        n_eval++; if (lat !== 3) begin n_fail++; $display("FAIL ee0_latency got %0d want 3", lat); end
        do_op(1'b0, 32'h8000_0000, 32'd3, lat, bb, db, dza);
        n_eval++; if (cociente !== 32'h2AAA_AAAA) begin n_fail++; $display("FAIL eemsb_coc got %h want %h", cociente, 32'h2AAA_AAAA); end
        n_eval++; if (resto !== 32'd2) begin n_fail++; $display("FAIL eemsb_rem got %h want %h", resto, 32'd2); end
        n_eval++; if (lat !== 35) begin n_fail++; $display("FAIL eemsb_latency got %0d want 35", lat); end
    endtask
`endif

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_cero();
        test_min_overflow();
        test_start_ignored();
        test_reset_abort();
`ifdef DIVISOR_EARLY_EXIT_EN
        test_early_exit();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule

// File: doc/divisor_secuencial_param.md
Name: divisor_secuencial_param

Overview:
- Parametrised multi-cycle integer divider; the next generation of the existing start/done divider.
- Adds a per-operation signed/unsigned mode, a busy flag, a divide-by-zero flag with defined results, and held results.
- Connects to the same testbench interface style: numerador/denominador in, cociente/resto out, start/done handshake.
- Restoring algorithm, one quotient bit per clock.

Parameters:
- SIZE, 32, operand and result width in bits (>= 4).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- signo  input  1  1 = signed two's-complement operation, 0 = unsigned; captured with start
- numerador  input  SIZE  dividend; captured with start
- denominador  input  SIZE  divisor; captured with start
- cociente  output  SIZE  quotient
- resto  output  SIZE  remainder
- done  output  1  one-cycle pulse when results become valid
- busy  output  1  high from the cycle after start is accepted until done
- div_cero  output  1  set with done when denominador == 0; held with results

Behaviour:
- Reset (asynchronous): state IDLE; cociente = 0, resto = 0, done = 0, busy = 0, div_cero = 0.
- States:
  - IDLE: on start, capture operands and signo, take magnitudes, record result signs.
    - Denominador != 0: go to CALC.
    - Denominador == 0: go to FIX.
  - CALC: SIZE iterations. Per cycle: rem = {rem, next dividend bit} - divisor, restored if negative. The partial remainder is SIZE+1 bits wide. Go to FIX after the last iteration.
  - FIX: apply signs and load output registers, then go to DONE.
  - DONE: done = 1 for this cycle only, busy = 0, then return to IDLE.
- Latency (macro off): start sampled at edge k gives done high after edge k+SIZE+2. Divide-by-zero gives done high after edge k+2.
- Unsigned mode: plain magnitude division.
- Signed mode (truncating division):
  - Quotient is negative iff operand signs differ.
  - Remainder takes the sign of numerador.
  - Magnitude of the most-negative value is 2^(SIZE-1), which fits in SIZE unsigned bits.
  - Overflow case MIN / -1 falls out naturally: cociente = MIN, resto = 0.
- Divide by zero (both modes): cociente = all ones, resto = numerador, div_cero = 1.
- cociente, resto and div_cero are held stable from done until the next accepted start.
- They update only in FIX.
- div_cero clears when the next start is accepted.
- start while busy (CALC/FIX/DONE) is ignored; no queueing.
- start held high continuously: a new operation is accepted in the IDLE cycle following DONE.
- Operand inputs are don't-care except on the accepted start cycle.
- rst_n low mid-operation: immediate abort to IDLE with all outputs at reset values. No done is produced for the aborted operation.

Optional Feature:
- Macro: DIVISOR_EARLY_EXIT_EN.
- Defined:
  - An extra NORM state follows IDLE and counts leading zeros lz of |numerador|, pre-shifting the dividend by lz.
  - CALC then runs SIZE-lz iterations.
  - If |numerador| == 0, CALC is skipped (cociente = 0, resto = 0).
  - Done high after edge k+3+(SIZE-lz).
  - Divide-by-zero path still bypasses NORM: done after edge k+2.
- Undefined: fixed latency SIZE+2 as above; no NORM state, no leading-zero logic.
- Results are identical in both builds.

Decomposition:
- Package divisor_pkg holds:
  - state enum estado_t (IDLE, NORM, CALC, FIX, DONE);
  - localparam computing counter width $clog2(SIZE+1);
  - constant function returning the divide-by-zero quotient pattern.
- One sub-module divisor_lzc (parametrised SIZE, combinational leading-zero counter), instantiated only under DIVISOR_EARLY_EXIT_EN.

Test Plan (SIZE = 32, macro off unless stated):
- Unsigned 100/7, start at edge k -> cociente 14, resto 2, div_cero 0. done high exactly one cycle after edge k+34, busy high edges k+1..k+33.
- Signed -7/2 -> cociente 0xFFFFFFFD, resto 0xFFFFFFFF. Signed 7/-2 -> 0xFFFFFFFD, resto 1. Unsigned 0xFFFFFFF9/2 -> 0x7FFFFFFC, resto 1.
- 55/0, signed and unsigned -> cociente 0xFFFFFFFF, resto 55, div_cero 1, done after edge k+2. Following 9/3 -> 3, 0, div_cero 0.
- Signed 0x80000000 / 0xFFFFFFFF -> cociente 0x80000000, resto 0. Unsigned same operands -> cociente 0, resto 0x80000000.
- Pulse start with 1/1 during CALC cycle 5 -> ignored; first result unchanged, no second done. Assert rst_n low during CALC cycle 10 -> outputs 0 immediately, no done. After release, 9/3 -> 3, 0.
- DIVISOR_EARLY_EXIT_EN: 5/1 (lz=29) -> cociente 5, resto 0, done after edge k+6. 0/3 -> 0, 0, done after edge k+3. 0x80000000/3 -> 0x2AAAAAAA, resto 2, done after edge k+35.
